// File: rtl/aa_sequencer_if.sv
// Request, pixel-lookup and result signals of the anti-aliasing sequencer.
// slave is the sequencer side; master is the requester/pixel-source side.
interface aa_sequencer_if;
   logic        in_valid;
   logic        in_ready;
   logic [10:0] in_x;
   logic [9:0]  in_y;
   logic        aa_en;
   logic [10:0] pix_x;
   logic [9:0]  pix_y;
   logic [7:0]  pix_r;
   logic [7:0]  pix_g;
   logic [7:0]  pix_b;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  r_new;
   logic [7:0]  g_new;
   logic [7:0]  b_new;

   modport slave (
      input  in_valid, in_x, in_y, aa_en,
      input  pix_r, pix_g, pix_b, out_ready,
      output in_ready, pix_x, pix_y,
      output out_valid, r_new, g_new, b_new
   );

   modport master (
      output in_valid, in_x, in_y, aa_en,
      output pix_r, pix_g, pix_b, out_ready,
      input  in_ready, pix_x, pix_y,
      input  out_valid, r_new, g_new, b_new
   );
endinterface

// File: rtl/aa_sequencer.sv
// 3x3 weighted anti-aliasing sequencer: issues clamped taps to a shared
// pixel port, accumulates the returned colour and holds the result.
module aa_sequencer #(
   parameter int H_ACTIVE = 1280,
   parameter int V_ACTIVE = 1024
) (
   input logic          clk,
   input logic          rst,
   aa_sequencer_if.slave bus
);

   localparam logic [10:0] X_MAX = 11'(H_ACTIVE - 1);
   localparam logic [9:0]  Y_MAX = 10'(V_ACTIVE - 1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      HOLD
   } state_t;

   state_t state;
   state_t state_nx;

   logic [10:0] cx;
   logic [9:0]  cy;
   logic        en;
   logic [3:0]  cnt;
   logic [3:0]  ntap;
   logic        accept;
   logic        fire;
   logic        last;

   logic [1:0]  col;
   logic [1:0]  row;
   logic [1:0]  sh;
   logic [10:0] tx;
   logic [9:0]  ty;

   logic [10:0] px_q;
   logic [9:0]  py_q;

   // Returned data lags the issued tap by two edges: v1/s1 then v2/s2
   logic        v1;
   logic        v2;
   logic [1:0]  s1;
   logic [1:0]  s2;

   logic [7:0]  samp   [3];
   logic [11:0] acc    [3];
   logic [11:0] acc_nx [3];
   logic [11:0] rnd    [3];
   logic [7:0]  res    [3];
   logic [7:0]  res_q  [3];

   assign ntap   = en ? 4'd9 : 4'd1;
   assign accept = bus.in_valid && (state == IDLE);
   assign fire   = (state == ISSUE) && (cnt < ntap);
   assign last   = (state == ISSUE) && (cnt == ntap);

   assign samp[0] = bus.pix_r;
   assign samp[1] = bus.pix_g;
   assign samp[2] = bus.pix_b;

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == HOLD);
   assign bus.pix_x     = px_q;
   assign bus.pix_y     = py_q;
   assign bus.r_new     = res_q[0];
   assign bus.g_new     = res_q[1];
   assign bus.b_new     = res_q[2];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:  if (accept) state_nx = ISSUE;
         ISSUE: if (last) state_nx = DRAIN;
         DRAIN: state_nx = HOLD;
         HOLD:  if (bus.out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Raster position of the current tap inside the 3x3 window
   always_comb begin
      row = 2'd1;
      col = 2'd1;
      if (en) begin
         row = (cnt >= 4'd6) ? 2'd2 : (cnt >= 4'd3) ? 2'd1 : 2'd0;
         col = 2'(cnt - 4'(row) * 4'd3);
      end
   end

   always_comb begin
      sh = 2'd0;
      if (en) begin
         if (col == 2'd1 && row == 2'd1) begin
            sh = 2'd2;
         end else if (col == 2'd1 || row == 2'd1) begin
            sh = 2'd1;
         end
      end
   end

   always_comb begin
      tx = cx;
      if (col == 2'd0 && cx != 11'd0) begin
         tx = cx - 11'd1;
      end else if (col == 2'd2 && cx != X_MAX) begin
         tx = cx + 11'd1;
      end
   end

   always_comb begin
      ty = cy;
      if (row == 2'd0 && cy != 10'd0) begin
         ty = cy - 10'd1;
      end else if (row == 2'd2 && cy != Y_MAX) begin
         ty = cy + 10'd1;
      end
   end

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         acc_nx[i] = acc[i];
         if (v2) begin
            acc_nx[i] = acc[i] + ({4'd0, samp[i]} << s2);
         end
         rnd[i] = acc_nx[i] + 12'd8;
         res[i] = en ? rnd[i][11:4] : acc_nx[i][7:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cx   <= '0;
         cy   <= '0;
         en   <= 1'b0;
         cnt  <= '0;
         px_q <= '0;
         py_q <= '0;
         v1   <= 1'b0;
         v2   <= 1'b0;
         s1   <= '0;
         s2   <= '0;
         for (int i = 0; i < 3; i++) begin
            acc[i]   <= '0;
            res_q[i] <= '0;
         end
      end else begin
         v1 <= fire;
         s1 <= sh;
         v2 <= v1;
         s2 <= s1;
         if (accept) begin
            cx  <= (bus.in_x > X_MAX) ? X_MAX : bus.in_x;
            cy  <= (bus.in_y > Y_MAX) ? Y_MAX : bus.in_y;
            en  <= bus.aa_en;
            cnt <= '0;
         end else if (fire) begin
            cnt <= cnt + 4'd1;
         end
         if (fire) begin
            px_q <= tx;
            py_q <= ty;
         end
         for (int i = 0; i < 3; i++) begin
            if (accept) begin
               acc[i] <= '0;
            end else begin
               acc[i] <= acc_nx[i];
            end
            if (state == DRAIN) begin
               res_q[i] <= res[i];
            end
         end
      end
   end

endmodule

// File: doc/aa_sequencer.md
AA_SEQUENCER -- requirements
Module: aa_sequencer

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 1280, meaning the visible width in pixels.
REQ-002 The block SHALL have parameter V_ACTIVE, default 1024, meaning the visible height in lines.
REQ-003 clk  input  1  the single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 in_valid  input  1  a pixel request is present.
REQ-006 in_ready  output  1  the block can accept a request.
REQ-007 in_x  input  11  request column.
REQ-008 in_y  input  10  request line.
REQ-009 aa_en  input  1  filter enable; 0 selects bypass.
REQ-010 pix_x  output  11  lookup column, driven to the shared display_pixel port.
REQ-011 pix_y  output  10  lookup line.
REQ-012 pix_r, pix_g, pix_b  input  8 each  lookup colour; valid exactly one cycle after pix_x/pix_y are presented.
REQ-013 out_valid  output  1  the result is present.
REQ-014 out_ready  input  1  the consumer accepts the result.
REQ-015 r_new, g_new, b_new  output  8 each  filtered colour.

Function
REQ-016 A request SHALL be accepted on a rising edge where in_valid and in_ready are both 1; in_x, in_y and aa_en SHALL be captured on that edge.
REQ-017 in_ready SHALL be 1 only in state IDLE.
REQ-018 The FSM SHALL have states IDLE, ISSUE, DRAIN and HOLD; IDLE->ISSUE on acceptance; ISSUE->DRAIN after the last tap is issued; DRAIN->HOLD after one cycle; HOLD->IDLE on the edge where out_ready=1.
REQ-019 With aa_en=1, ISSUE SHALL present 9 taps on consecutive cycles in raster order: (x-1,y-1), (x,y-1), (x+1,y-1), (x-1,y), (x,y), (x+1,y), (x-1,y+1), (x,y+1), (x+1,y+1).
REQ-020 With aa_en=0, ISSUE SHALL present only tap (x,y), for a single cycle.
REQ-021 Tap coordinates SHALL be clamped: columns to 0..H_ACTIVE-1 and lines to 0..V_ACTIVE-1, with no wrap-around.
REQ-022 Tap weights SHALL be 1 for corners, 2 for edges and 4 for the centre, applied as left shifts.
REQ-023 Per channel, a 12-bit accumulator SHALL clear on acceptance and add each weighted sample in the cycle its data returns.
REQ-024 With aa_en=1, the result SHALL be (acc+8)>>4, truncated to 8 bits; it cannot overflow because the maximum is 4088.
REQ-025 With aa_en=0, the result SHALL be the centre sample unmodified.
REQ-026 Latency SHALL be measured from the acceptance edge T: out_valid rises at T+11 with aa_en=1 and at T+3 with aa_en=0.
REQ-027 In HOLD, out_valid SHALL stay 1 and r_new, g_new and b_new SHALL stay stable until out_ready=1.
REQ-028 The next request SHALL NOT be accepted before the cycle after HOLD exits; there is no overlap of requests.
REQ-029 Outside ISSUE, pix_x and pix_y SHALL hold their last value.
REQ-030 in_x and in_y beyond the active area SHALL be clamped before the offsets are applied.

Reset
REQ-031 While rst=1, the block SHALL be in IDLE with in_ready=1, out_valid=0, r_new, g_new and b_new at 0, pix_x and pix_y at 0, and the accumulators at 0.
REQ-032 Reset asserted mid-operation SHALL abandon the request, with no result produced, and the block SHALL be ready on the first edge after release.

Verification
REQ-033 Uniform field 200/100/50, request (640,512), aa_en=1 -> out 200/100/50 at T+11; pix sequence matches REQ-019.
REQ-034 Centre-only 255 on all channels, neighbours 0, aa_en=1 -> out 64/64/64.
REQ-035 Request (0,0) -> pix taps (0,0),(0,0),(1,0),(0,0),(0,0),(1,0),(0,1),(0,1),(1,1); request (1279,1023) -> column and line clamped to 1279 and 1023.
REQ-036 aa_en=0, request (10,20) with centre 17/34/51 -> one tap at (10,20), out 17/34/51 at T+3.
REQ-037 out_ready held 0 for 5 cycles in HOLD -> out_valid and data stable and in_ready=0 throughout; accepted on release; IDLE the next cycle.
REQ-038 rst pulsed during ISSUE tap 4 -> out_valid never asserts, in_ready=1 after release, and a following request gives the correct result.
